// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder cell adds two WIDTH-bit operands
// LSB first, one bit per clock, with start/busy/done handshake, carry-out and overflow.

module full_adder (
   input  logic in1,
   input  logic in2,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = in1 ^ in2 ^ cin;
   assign cout = (in1 & in2) | (cin & (in1 ^ in2));
endmodule

// Handshake: start is sampled only in IDLE; the accepting edge also captures
// a, b and cin. busy is high for the WIDTH RUN cycles; done is a one-cycle pulse
// marking the cycle in which sum/cout/ovf have just been updated.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic [1:0]       dbg_state
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] ss_q, ss_d;
   logic             c_q, c_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             cmsb_q, cmsb_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic fa_s, fa_co;
   logic ss_lsb_unused;

   full_adder u_fa (
      .in1  (sa_q[0]),
      .in2  (sb_q[0]),
      .cin  (c_q),
      .sum  (fa_s),
      .cout (fa_co)
   );

   // The oldest partial-sum bit is shifted out and never needed.
   assign ss_lsb_unused = ss_q[0];

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      ss_d    = ss_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      cmsb_d  = cmsb_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sa_d    = a;
               sb_d    = b;
               c_d     = cin;
               ss_d    = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            ss_d  = {fa_s, ss_q[WIDTH-1:1]};
            c_d   = fa_co;
            cnt_d = cnt_q + CW'(1);
            // Carry out of bit WIDTH-2 is the carry into the MSB.
            if (cnt_q == CNT_PENULT) cmsb_d = fa_co;
            if (cnt_q == CNT_LAST) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               sum_d   = {fa_s, ss_q[WIDTH-1:1]};
               cout_d  = fa_co;
               ovf_d   = cmsb_q ^ fa_co;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         ss_q    <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         cmsb_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         ss_q    <= ss_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         cmsb_q  <= cmsb_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign dbg_state = state_q;

endmodule
